// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit in front of the word-wide SPRAM.
// Lane rules for stores and loads live here so every datapath agrees on them.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      LOAD_WAIT = 2'b01,
      RESP      = 2'b10
   } lsu_state_t;

   // Low address bits are masked to the natural alignment of the access size.
   function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [1:0] off;
      case (size)
         SZ_BYTE: off = addr_lo;
         SZ_HALF: off = {addr_lo[1], 1'b0};
         default: off = 2'b00;
      endcase
      return off;
   endfunction

   function automatic logic [3:0] store_wen(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] wen;
      case (size)
         SZ_BYTE: wen = 4'b0001 << addr_lo;
         SZ_HALF: wen = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: wen = 4'b1111;
      endcase
      return wen;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] data;
      case (size)
         SZ_BYTE: data = {4{wdata[7:0]}};
         SZ_HALF: data = {2{wdata[15:0]}};
         default: data = wdata;
      endcase
      return data;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a 32-bit memory word.
// Shared between the SPRAM path and any later cache path.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] load_data
);

   logic [31:0] shifted_s;

   assign shifted_s = mem_rdata >> {offset, 3'b000};

   // Word loads always arrive with offset 0, so the shifted value is the raw word.
   always_comb begin
      load_data = shifted_s;
      case (size)
         SZ_BYTE: begin
            if (is_unsigned) begin
               load_data = {24'h000000, shifted_s[7:0]};
            end else begin
               load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
         end
         SZ_HALF: begin
            if (is_unsigned) begin
               load_data = {16'h0000, shifted_s[15:0]};
            end else begin
               load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
         end
         default: load_data = shifted_s;
      endcase
   end

endmodule

// File: rtl/lsu_spram.sv
// Load/store unit: core valid/ready requests to byte-enabled SPRAM accesses with a one-cycle read.
// Optional feature macro LSU_MISALIGN_TRAP_EN rejects misaligned and reserved-size requests.
module lsu_spram
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [3:0]        mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t  state_r;
   logic [1:0]  off_r;
   logic [1:0]  size_r;
   logic        uns_r;
   logic        resp_valid_r;
   logic        resp_err_r;
   logic [31:0] resp_rdata_r;

   logic        accept_s;
   logic        err_s;
   logic [1:0]  size_eff_s;
   logic [31:0] load_data_s;
   logic        addr_unused_s;

   assign addr_unused_s = ^req_addr[31:ADDR_W+2];
   assign req_ready     = (state_r != LOAD_WAIT);
   assign accept_s      = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
   assign err_s      = is_misaligned(req_size, req_addr[1:0]);
   assign size_eff_s = req_size;
`else
   assign err_s      = 1'b0;
   assign size_eff_s = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
`endif

   // Store lane steering; the address is always presented so loads read in the accept cycle.
   always_comb begin
      mem_addr  = req_addr[ADDR_W+1:2];
      mem_wdata = store_data(size_eff_s, req_wdata);
      if (accept_s && req_write && !err_s) begin
         mem_wen = store_wen(size_eff_s, req_addr[1:0]);
      end else begin
         mem_wen = 4'b0000;
      end
   end

   lsu_load_align u_align (
      .mem_rdata   (mem_rdata),
      .offset      (off_r),
      .size        (size_r),
      .is_unsigned (uns_r),
      .load_data   (load_data_s)
   );

   // Control FSM and response registers; RESP can accept a new request in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         off_r        <= 2'b00;
         size_r       <= SZ_BYTE;
         uns_r        <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
      end else begin
         resp_valid_r <= 1'b0;
         case (state_r)
            IDLE, RESP: begin
               if (accept_s) begin
                  if (err_s) begin
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_rdata_r <= 32'h0000_0000;
                  end else if (req_write) begin
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b0;
                     resp_rdata_r <= 32'h0000_0000;
                  end else begin
                     state_r <= LOAD_WAIT;
                     off_r   <= lane_offset(size_eff_s, req_addr[1:0]);
                     size_r  <= size_eff_s;
                     uns_r   <= req_unsigned;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD_WAIT: begin
               state_r      <= RESP;
               resp_valid_r <= 1'b1;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= load_data_s;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;

endmodule

// File: doc/lsu_spram.md
# lsu_spram

Load/store unit between the pipelined RISC-V core's memory stage and the `spram128kB` data memory. It turns a core request into word-addressed SPRAM accesses:
- stores become per-byte write enables with lane-replicated data;
- loads become a one-cycle synchronous read, followed by lane extraction and sign/zero extension.

It replaces the tied `{4{mem_write}}` enable wiring and gives the core a valid/ready stall interface for byte, halfword and word accesses.

## Interface
Parameters:
- `ADDR_W`, 15, SPRAM word-address width; byte address bits `[ADDR_W+1:2]` are used.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  LSU can accept this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  load zero-extends (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  access was rejected.
- `mem_wen`  out  4  SPRAM byte write enables.
- `mem_addr`  out  ADDR_W  SPRAM word address.
- `mem_wdata`  out  32  SPRAM write data.
- `mem_rdata`  in  32  SPRAM read data, valid the cycle after the address.

## Operation
- A request is accepted on a cycle with `req_valid && req_ready`.
- FSM states and transitions:
  - IDLE: on store accept go to RESP; on load accept go to LOAD_WAIT.
  - LOAD_WAIT: capture the extended read data and go to RESP.
  - RESP: `resp_valid`=1; if a new accept occurs, branch exactly as from IDLE, otherwise go to IDLE.
- `req_ready` = (state != LOAD_WAIT).
- `mem_addr`, `mem_wen` and `mem_wdata` are driven combinationally in the accept cycle. `mem_wen`=0 whenever there is no store accept.
- Store lanes:
  - byte: `mem_wen` = 1<<addr[1:0]; data = {4{wdata[7:0]}}.
  - half: `mem_wen` = addr[1] ? 1100 : 0011; data = {2{wdata[15:0]}}.
  - word: `mem_wen` = 1111; data = wdata.
- Load: the byte offset and size are latched at accept. In LOAD_WAIT the selected lane of `mem_rdata` is shifted down and then extended: sign-extended if `req_unsigned`=0, zero-extended if 1. Word loads pass through unchanged.
- Responses cannot be back-pressured; the core must consume `resp_valid` when it pulses.

## Timing
- Reset values: state IDLE, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `req_ready`=1, `mem_wen`=0.
- Latency, with accept at cycle N:
  - store: memory written at the edge ending N; `resp_valid` at N+1.
  - load: `mem_addr` at N; data captured at the edge ending N+1; `resp_valid` and `resp_rdata` at N+2.
- Throughput: one store per cycle, back-to-back through RESP; one load per 2 cycles.
- A store immediately after a load to the same word is accepted in RESP of the load. The load data is already registered, so it is unaffected.
- Reset asserted mid-load drops the access: no response, state returns to IDLE.
- `resp_rdata` holds its value until the next response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Requests that are rejected: half with addr[0]=1, word with addr[1:0]≠0, and `req_size`=11.
  - For a rejected request: `mem_wen`=0, no read is performed, and the FSM goes straight to RESP.
  - Response at N+1 with `resp_err`=1 and `resp_rdata`=0.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned low address bits are ignored: half uses addr[1], word uses neither.
  - `req_size`=11 is treated as word.
  - `resp_err` is tied to 0.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state enum `IDLE`/`LOAD_WAIT`/`RESP`;
  - `lsu_state_t`.
- Sub-module `lsu_load_align`: combinational lane select plus extension, taking `mem_rdata`, offset, size and unsigned flag. It is reused by any future cache path.
- The top level holds the FSM, the store lane logic and the response registers.

## Test plan
- **sb:** `sb` 0xA5 to address 0x65 → `mem_wen`=0010, `mem_wdata`=0xA5A5A5A5, `resp_valid` at N+1. A following `lw` from 0x64 returns a word with byte 1 = 0xA5.
- **sw/lw with extension:**
  - `sw` 0x8000F0FF to 0x60, then `lh` at 0x62 → `resp_rdata`=0xFFFF8000 at N+2.
  - `lhu` at 0x62 → 0x00008000.
  - `lb` at 0x60 → 0xFFFFFFFF.
- **Back-to-back:** three stores on consecutive cycles → `req_ready` held high, three `resp_valid` pulses at N+1..N+3.
- **Load pacing:** `lw` followed by a held request → `req_ready`=0 in LOAD_WAIT, second request accepted at N+2.
- **Misalignment:** `sw` to 0x62.
  - With `LSU_MISALIGN_TRAP_EN`: `mem_wen`=0000, `resp_err`=1 at N+1, memory unchanged.
  - Without it: word 0x60 is written, `resp_err`=0.
- **Reset mid-load:** assert `reset` during LOAD_WAIT → no `resp_valid`, `req_ready`=1 and `resp_rdata`=0 immediately.
